vpu_issue_seq: RTL and testbench

//  Instruction issue sequencer in front of the VPU datapath (vpu_top).

---
 rtl/vpu_pkg.sv | 27 ++
 rtl/vpu_inst_fifo.sv | 49 ++++
 rtl/vpu_issue_seq.sv | 124 ++++++++++++
 tb/tb_vpu_issue_seq.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vpu_pkg.sv
// Shared types for the VPU issue path: instruction layout, opcodes, sequencer states.
package vpu_pkg;

  localparam int INST_W = 32;

  // 32-bit VPU instruction; opcode sits in the low nibble.
  typedef struct packed {
    logic [15:0] const_addr;
    logic [3:0]  c_addr;
    logic [3:0]  b_addr;
    logic [3:0]  a_addr;
    logic [3:0]  opcode;
  } inst_t;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_MAC = 4'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/vpu_inst_fifo.sv
// Small instruction FIFO. Pointers carry one extra wrap bit so full and empty
// are told apart without a separate occupancy counter.
module vpu_inst_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, rd_q;
  logic [AW:0]      wr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign wr_d    = push_i ? wr_q + (AW+1)'(1) : wr_q;
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  // Pointer update; flush drops everything up to the write pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      if (flush_i)
        rd_q <= wr_d;
      else if (pop_i)
        rd_q <= rd_q + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since empty gates every read.
  always_ff @(posedge clk) begin
    if (push_i)
      mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/vpu_issue_seq.sv
// Issue sequencer: queues host instructions, issues one at a time to the VPU,
// screens illegal opcodes, watches for a stuck VPU and counts retirements.
module vpu_issue_seq
  import vpu_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int OP_W       = 4,
  parameter int MAX_OPCODE = 4,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst_in,
  input  logic             inst_valid,
  output logic             inst_ready,
  input  logic             flush,
  output logic [31:0]      vpu_inst,
  output logic             vpu_start,
  input  logic             vpu_done,
  output logic             busy,
  output logic             err_illegal,
  output logic             err_timeout,
  input  logic             clear_err,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  seq_state_t        state_q;
  inst_t             vpu_inst_q;
  logic              vpu_start_q;
  logic              err_illegal_q, err_timeout_q;
  logic [CNT_W-1:0]  retired_q;
  logic [WD_W-1:0]   wdog_q;

  logic [INST_W-1:0] head;
  logic              fifo_full, fifo_empty;
  logic              push, pop;
  logic              head_legal;

  assign inst_ready = !fifo_full && !flush;
  assign push       = inst_valid && inst_ready;
  assign pop        = (state_q == ISSUE);
  assign head_legal = (head[OP_W-1:0] <= OP_W'(MAX_OPCODE));

  vpu_inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INST_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .din_i   (inst_in),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Sequencer FSM. The head is latched into vpu_inst on the IDLE->ISSUE edge so
  // instruction and start pulse are both registered and valid throughout ISSUE.
  // A head that is flushed while still in IDLE is never issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      vpu_inst_q    <= '0;
      vpu_start_q   <= 1'b0;
      err_illegal_q <= 1'b0;
      err_timeout_q <= 1'b0;
      retired_q     <= '0;
      wdog_q        <= '0;
    end else begin
      vpu_start_q <= 1'b0;
      // Clear first so a same-cycle error below takes priority.
      if (clear_err) begin
        err_illegal_q <= 1'b0;
        err_timeout_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (!fifo_empty && !flush) begin
            state_q     <= ISSUE;
            vpu_inst_q  <= inst_t'(head);
            vpu_start_q <= head_legal;
          end
        end
        ISSUE: begin
          wdog_q <= '0;
          if (vpu_start_q) begin
            state_q <= WAIT;
          end else begin
            err_illegal_q <= 1'b1;
            state_q       <= IDLE;
          end
        end
        WAIT: begin
          if (vpu_done) begin
            retired_q <= retired_q + CNT_W'(1);
            wdog_q    <= '0;
            state_q   <= IDLE;
          end else if (TIMEOUT != 0 && wdog_q == WD_LAST) begin
            err_timeout_q <= 1'b1;
            wdog_q        <= '0;
            state_q       <= IDLE;
          end else begin
            wdog_q <= wdog_q + WD_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vpu_inst    = vpu_inst_q;
  assign vpu_start   = vpu_start_q;
  assign err_illegal = err_illegal_q;
  assign err_timeout = err_timeout_q;
  assign retired_cnt = retired_q;
  assign busy        = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_vpu_issue_seq.sv
// Bench for vpu_issue_seq: accepted legal instructions go into an expected-issue
// queue; a monitor compares every vpu_start against it. A responder models the VPU.
module tb_vpu_issue_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst_in = '0;
  logic        inst_valid = 1'b0;
  logic        inst_ready;
  logic        flush = 1'b0;
  logic [31:0] vpu_inst;
  logic        vpu_start;
  logic        vpu_done;
  logic        busy;
  logic        err_illegal, err_timeout;
  logic        clear_err = 1'b0;
  logic [3:0]  retired_cnt;

  logic        resp_done = 1'b0;
  logic        man_done  = 1'b0;
  int          done_lat  = 3;
  bit          hold_done = 1'b0;

  int          checks = 0;
  int          failures = 0;
  int          exp_cnt = 0;
  logic [31:0] exp_q [$];

  assign vpu_done = resp_done | man_done;

  always #5 clk = ~clk;

  vpu_issue_seq #(
    .DEPTH(4), .OP_W(4), .MAX_OPCODE(4), .TIMEOUT(8), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .inst_in(inst_in), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .flush(flush), .vpu_inst(vpu_inst),
    .vpu_start(vpu_start), .vpu_done(vpu_done), .busy(busy),
    .err_illegal(err_illegal), .err_timeout(err_timeout),
    .clear_err(clear_err), .retired_cnt(retired_cnt)
  );

  // VPU model: answers each start with a done pulse done_lat cycles later.
  initial forever begin
    @(negedge clk);
    if (!rst && vpu_start && !hold_done) begin
      repeat (done_lat) @(negedge clk);
      resp_done = 1'b1;
      @(negedge clk);
      resp_done = 1'b0;
    end
  end

  // Issue monitor: every start must match the oldest expected instruction.
  initial forever begin
    logic [31:0] e;
    @(negedge clk);
    if (!rst && vpu_start) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL issue_order: unexpected vpu_start with vpu_inst=%h", vpu_inst);
      end else begin
        e = exp_q.pop_front();
        if (vpu_inst !== e) begin
          failures++;
          $display("FAIL issue_order: vpu_inst=%h expected=%h", vpu_inst, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", nm, act, exp_v);
    end
  endtask

  task automatic push(input logic [31:0] d, input bit legal);
    int n = 0;
    inst_in = d;
    inst_valid = 1'b1;
    #1;
    while (!inst_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!inst_ready) begin
      checks++; failures++;
      $display("FAIL push_wait: inst_ready stuck low for inst=%h", d);
    end else if (legal) begin
      exp_q.push_back(d);
    end
    @(negedge clk);
    inst_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || vpu_done) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++; failures++;
      $display("FAIL wait_idle: busy stuck at %b", busy);
    end
  endtask

  task automatic wait_start();
    int n = 0;
    while (!vpu_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!vpu_start) begin
      checks++; failures++;
      $display("FAIL wait_start: vpu_start never seen");
    end
  endtask

  initial begin
    bit seen;
    // Reset
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_inst_ready", 32'(inst_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_vpu_start", 32'(vpu_start), 32'd0);
    chk("rst_vpu_inst", vpu_inst, 32'h0);
    chk("rst_errs", {30'd0, err_illegal, err_timeout}, 32'd0);
    chk("rst_cnt", 32'(retired_cnt), 32'd0);

    // Single instruction, exact latency: push in cycle 0, start in 2, done in 6
    done_lat = 4;
    push(32'h0000_1421, 1'b1);
    chk("t1_no_start_c1", 32'(vpu_start), 32'd0);
    tick();
    chk("t1_start_c2", 32'(vpu_start), 32'd1);
    chk("t1_inst_c2", vpu_inst, 32'h0000_1421);
    repeat (4) tick();
    chk("t1_busy_c6", 32'(busy), 32'd1);
    tick();
    exp_cnt++;
    chk("t1_cnt_c7", 32'(retired_cnt), 32'(exp_cnt % 16));
    chk("t1_busy_c7", 32'(busy), 32'd0);

    // Back-to-back pushes fill the FIFO; ready stays low even on a popping cycle
    done_lat = 3;
    for (int i = 0; i < 5; i++)
      push({16'(i + 1), 12'h321, 4'(i % 5)}, 1'b1);
    chk("t2_full_ready", 32'(inst_ready), 32'd0);
    wait_start();
    chk("t2_ready_on_pop", 32'(inst_ready), 32'd0);
    push(32'h0006_3213, 1'b1);
    wait_idle();
    exp_cnt += 6;
    chk("t2_cnt", 32'(retired_cnt), 32'(exp_cnt % 16));

    // Opcode screening at the boundary (4 legal, 5 and F illegal)
    done_lat = 2;
    push(32'h0000_ABC5, 1'b0);
    wait_idle();
    chk("t3_err_illegal", 32'(err_illegal), 32'd1);
    chk("t3_illegal_inst", vpu_inst, 32'h0000_ABC5);
    chk("t3_err_timeout", 32'(err_timeout), 32'd0);
    push(32'h0000_0004, 1'b1);
    wait_idle();
    exp_cnt++;
    chk("t3_op4_cnt", 32'(retired_cnt), 32'(exp_cnt % 16));
    push(32'h1234_567F, 1'b0);
    push(32'h0000_0003, 1'b1);
    wait_idle();
    exp_cnt++;
    chk("t3_after_F_cnt", 32'(retired_cnt), 32'(exp_cnt % 16));
    chk("t3_sticky", 32'(err_illegal), 32'd1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("t3_cleared", 32'(err_illegal), 32'd0);

    // clear_err held while a new illegal op arrives: the error wins for one cycle
    clear_err = 1'b1;
    push(32'h0000_000F, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (err_illegal) seen = 1'b1;
      else tick();
    end
    chk("t3_err_wins", 32'(seen), 32'd1);
    tick();
    chk("t3_clear_after", 32'(err_illegal), 32'd0);
    clear_err = 1'b0;
    wait_idle();

    // vpu_done while idle is ignored
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    tick();
    chk("t3_stray_done", 32'(retired_cnt), 32'(exp_cnt % 16));

    // Watchdog: first op never completes, second one queued behind it issues
    hold_done = 1'b1;
    push(32'h0000_2223, 1'b1);
    push(32'h0000_4441, 1'b1);
    wait_start();
    repeat (8) tick();
    chk("t4_no_to_yet", 32'(err_timeout), 32'd0);
    tick();
    chk("t4_timeout", 32'(err_timeout), 32'd1);
    chk("t4_cnt_same", 32'(retired_cnt), 32'(exp_cnt % 16));
    hold_done = 1'b0;
    wait_idle();
    exp_cnt++;
    chk("t4_next_retired", 32'(retired_cnt), 32'(exp_cnt % 16));
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("t4_cleared", 32'(err_timeout), 32'd0);

    // Flush during WAIT of the first of three; a same-cycle push is refused
    done_lat = 6;
    push(32'h0000_0101, 1'b1);
    push(32'h0000_0202, 1'b1);
    push(32'h0000_0303, 1'b1);
    flush = 1'b1;
    inst_in = 32'h0000_0404;
    inst_valid = 1'b1;
    #1;
    chk("t5_ready_flush", 32'(inst_ready), 32'd0);
    tick();
    flush = 1'b0;
    inst_valid = 1'b0;
    exp_q.delete();
    wait_idle();
    repeat (6) tick();
    exp_cnt++;
    chk("t5_cnt", 32'(retired_cnt), 32'(exp_cnt % 16));
    chk("t5_busy", 32'(busy), 32'd0);

    // Counter wrap: push the total past 16 retirements
    done_lat = 1;
    for (int i = 0; i < 7; i++)
      push({20'h0, 8'(i), 4'(i % 5)}, 1'b1);
    wait_idle();
    exp_cnt += 7;
    chk("t6_wrap", 32'(retired_cnt), 32'(exp_cnt % 16));

    // Reset in the middle of WAIT with an error set and an instruction queued
    push(32'h0000_0009, 1'b0);
    wait_idle();
    chk("t7_pre_err", 32'(err_illegal), 32'd1);
    hold_done = 1'b1;
    push(32'h0000_0111, 1'b1);
    push(32'h0000_0222, 1'b1);
    wait_start();
    repeat (2) tick();
    exp_q.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    chk("t7_inst_ready", 32'(inst_ready), 32'd1);
    chk("t7_busy", 32'(busy), 32'd0);
    chk("t7_vpu_start", 32'(vpu_start), 32'd0);
    chk("t7_vpu_inst", vpu_inst, 32'h0);
    chk("t7_errs", {30'd0, err_illegal, err_timeout}, 32'd0);
    chk("t7_cnt", 32'(retired_cnt), 32'd0);
    repeat (4) tick();
    chk("t7_stays_idle", 32'(busy), 32'd0);
    hold_done = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
